// File: rtl/cat_packer.sv
// cat_packer: packs 4-bit cat nibbles (first nibble in [3:0]) into OUT_WIDTH-bit words on a valid/ready output.
// Optional macro CAT_PACKER_PARITY_EN adds a word_par output (XOR over the word's valid nibbles).
`default_nettype none

module cat_packer #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [3:0]                           cat,
  input  logic                                 cat_valid,
  input  logic                                 cat_last,
  output logic                                 cat_ready,
  output logic [OUT_WIDTH-1:0]                 word,
  output logic [$clog2(OUT_WIDTH/4+1)-1:0]     word_cnt,
  output logic                                 word_valid,
  input  logic                                 word_ready
`ifdef CAT_PACKER_PARITY_EN
  ,
  output logic                                 word_par
`endif
);

  localparam int NIBBLES = OUT_WIDTH / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                r_state;
  logic [OUT_WIDTH-1:0]  r_acc;
  logic [CNT_W-1:0]      r_acc_cnt;
  logic [OUT_WIDTH-1:0]  r_word;
  logic [CNT_W-1:0]      r_word_cnt;
`ifdef CAT_PACKER_PARITY_EN
  logic                  r_word_par;
`endif

  logic [OUT_WIDTH-1:0]  w_nib_ext;
  logic [OUT_WIDTH-1:0]  w_merged;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_complete;

  assign word_valid = (r_state == FULL);
  assign cat_ready  = !word_valid || word_ready;
  assign w_accept   = cat_valid && cat_ready;
  assign w_xfer     = word_valid && word_ready;
  assign w_complete = w_accept && ((r_acc_cnt == CNT_W'(NIBBLES - 1)) || cat_last);

  // Positions above the write slot are always zero in r_acc, since it is
  // cleared on every completion and only filled from the bottom up.
  assign w_nib_ext  = OUT_WIDTH'(cat);
  assign w_merged   = r_acc | (w_nib_ext << (4 * r_acc_cnt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_acc      <= '0;
      r_acc_cnt  <= '0;
      r_word     <= '0;
      r_word_cnt <= '0;
`ifdef CAT_PACKER_PARITY_EN
      r_word_par <= 1'b0;
`endif
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_complete) begin
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_xfer && !w_complete) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase

      if (w_complete) begin
        r_word     <= w_merged;
        r_word_cnt <= r_acc_cnt + 1'b1;
`ifdef CAT_PACKER_PARITY_EN
        r_word_par <= ^w_merged;
`endif
        r_acc      <= '0;
        r_acc_cnt  <= '0;
      end else if (w_accept) begin
        r_acc      <= w_merged;
        r_acc_cnt  <= r_acc_cnt + 1'b1;
      end
    end
  end

  assign word     = r_word;
  assign word_cnt = r_word_cnt;
`ifdef CAT_PACKER_PARITY_EN
  assign word_par = r_word_par;
`endif

endmodule

`default_nettype wire
